intro_sequencer: RTL

//  Parametrised intro slideshow sequencer. Steps through NUM_SLIDES panel images

---
 rtl/intro_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/intro_sequencer.sv
// -----------------------------------------------------------------------------
// intro_sequencer
//
// Intro slideshow sequencer. It steps through NUM_SLIDES slide images that are
// shown across NUM_PANELS side-by-side panels, filled left to right. Each slide
// is held for HOLD_FRAMES frames before the next one appears. When a new row
// starts in panel 0, every other panel is blanked. After the last slide's hold
// expires, all panels clear and `done` stays high while `enable` is held.
// The current pixel (DrawX, DrawY) is decoded combinationally into a hit flag,
// the slide id under the pixel and a ROM address within that panel's image.
//
// Configuration macro:
//   INTRO_SKIP_EN - when defined, a rising edge on `skip` while showing
//                   advances one slide at once. When undefined, `skip` is
//                   ignored and no edge-detect flop is built.
//
// Ports:
//   frame_clk      in   1                    frame-rate clock; all state on posedge
//   Reset_n        in   1                    synchronous active-low reset
//   enable         in   1                    high while the game is in its intro state
//   pause          in   1                    freezes the hold counter
//   skip           in   1                    level; a rising edge advances one slide
//   DrawX, DrawY   in   10                   current pixel coordinates
//   panel_slide    out  NUM_PANELS*SLIDE_W   slide id per panel, panel 0 in LSBs
//   is_sub         out  NUM_PANELS           bit p set when panel p shows a slide
//   is_intro       out  1                    pixel lies inside a panel showing a slide
//   intro_slide    out  SLIDE_W              slide id under the pixel, 0 on a miss
//   intro_address  out  20                   ROM address of the pixel, 0 on a miss
//   done           out  1                    the last slide's hold has expired
// -----------------------------------------------------------------------------
module intro_sequencer #(
    parameter int NUM_SLIDES  = 10,
    parameter int NUM_PANELS  = 2,
    parameter int HOLD_FRAMES = 300,
    parameter int PANEL_X0    = 79,
    parameter int PANEL_PITCH = 281,
    parameter int PANEL_Y0    = 80,
    parameter int PANEL_W     = 199,
    parameter int PANEL_H     = 107,
    parameter int SLIDE_W     = 4
) (
    input  logic                             frame_clk,
    input  logic                             Reset_n,
    input  logic                             enable,
    input  logic                             pause,
    input  logic                             skip,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    output logic [NUM_PANELS*SLIDE_W-1:0]    panel_slide,
    output logic [NUM_PANELS-1:0]            is_sub,
    output logic                             is_intro,
    output logic [SLIDE_W-1:0]               intro_slide,
    output logic [19:0]                      intro_address,
    output logic                             done
);

    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SLIDE_W-1:0] cur_q, cur_d;
    logic               done_q, done_d;
    logic [SLIDE_W-1:0] panels_q [NUM_PANELS];
    logic [SLIDE_W-1:0] panels_d [NUM_PANELS];
    logic               skip_hit;
    logic               advance;
    int                 adv_idx;

    // ------------------------------------------------------------------
    // Skip edge detection (optional)
    // ------------------------------------------------------------------
`ifdef INTRO_SKIP_EN
    logic skip_q;

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) skip_q <= 1'b0;
        else          skip_q <= skip;
    end

    // A held skip produces exactly one cycle of skip_hit.
    assign skip_hit = skip & ~skip_q;
`else
    logic unused_skip;
    assign unused_skip = skip;
    assign skip_hit    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge, regardless of order.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            done_q  <= 1'b0;
            // NOTE: the panel array is a handful of flops, not a RAM, so it is
            // safe (and required) to reset every entry.
            for (int p = 0; p < NUM_PANELS; p++) panels_q[p] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
            for (int p = 0; p < NUM_PANELS; p++) panels_q[p] <= panels_d[p];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Expiry only counts while not paused; a skip edge wins over pause.
    assign advance = skip_hit || (!pause && cnt_q == CNT_W'(HOLD_FRAMES - 1));

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        done_d  = done_q;
        adv_idx = 0;
        for (int p = 0; p < NUM_PANELS; p++) panels_d[p] = panels_q[p];

        if (!enable) begin
            // Abort from any state; re-raising enable restarts at slide 1.
            state_d = IDLE;
            cnt_d   = '0;
            cur_d   = '0;
            done_d  = 1'b0;
            for (int p = 0; p < NUM_PANELS; p++) panels_d[p] = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    cur_d   = SLIDE_W'(1);
                    done_d  = 1'b0;
                    for (int p = 0; p < NUM_PANELS; p++) panels_d[p] = '0;
                    panels_d[0] = SLIDE_W'(1);
                end

                SHOW: begin
                    if (advance) begin
                        cnt_d = '0;
                        if (cur_q == SLIDE_W'(NUM_SLIDES)) begin
                            state_d = DONE;
                            cur_d   = '0;
                            done_d  = 1'b1;
                            for (int p = 0; p < NUM_PANELS; p++) panels_d[p] = '0;
                        end else begin
                            cur_d = cur_q + 1'b1;
                            // New slide number is cur_q+1, so its panel is
                            // (cur_q+1-1) % NUM_PANELS.
                            adv_idx = int'(cur_q) % NUM_PANELS;
                            for (int p = 0; p < NUM_PANELS; p++) begin
                                if (p == adv_idx)
                                    panels_d[p] = cur_q + 1'b1;
                                else if (adv_idx == 0)
                                    panels_d[p] = '0;
                            end
                        end
                    end else if (!pause) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    done_d = 1'b1;
                    for (int p = 0; p < NUM_PANELS; p++) panels_d[p] = '0;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Panel outputs
    // ------------------------------------------------------------------
    always_comb begin
        panel_slide = '0;
        is_sub      = '0;
        for (int p = 0; p < NUM_PANELS; p++) begin
            panel_slide[p*SLIDE_W +: SLIDE_W] = panels_q[p];
            is_sub[p]                         = (panels_q[p] != '0);
        end
    end

    assign done = done_q;

    // ------------------------------------------------------------------
    // Pixel decode (combinational, 20-bit unsigned)
    // ------------------------------------------------------------------
    logic [19:0] px, py, x0;

    always_comb begin
        px            = {10'd0, DrawX};
        py            = {10'd0, DrawY};
        x0            = '0;
        is_intro      = 1'b0;
        intro_slide   = '0;
        intro_address = '0;
        // Scan from the highest panel down so the lowest index wins on overlap.
        for (int p = NUM_PANELS - 1; p >= 0; p--) begin
            x0 = 20'(PANEL_X0 + p * PANEL_PITCH);
            if (panels_q[p] != '0 &&
                px >= x0 && px < x0 + 20'(PANEL_W) &&
                py >= 20'(PANEL_Y0) && py < 20'(PANEL_Y0 + PANEL_H)) begin
                is_intro      = 1'b1;
                intro_slide   = panels_q[p];
                intro_address = (px - x0) + (py - 20'(PANEL_Y0)) * 20'(PANEL_W);
            end
        end
    end

endmodule
